frame_pixel_streamer: RTL and testbench
=======================================

// Module: frame_pixel_streamer
// PURPOSE
//  Upstream feeder for the UART pixel sender. On a start pulse it walks the camera frame
//  buffer from address 0 to FRAME_W*FRAME_H-1. It first emits one SYNC_WORD, then every
//  12-bit RGB444 pixel, each as one valid/ready transfer into send_pixel (pixel/valid_in/ready_out).
//  Sits between the frame-buffer read port and send_pixel in the FPGA-to-Nano WiFi path.
// PARAMETERS
//  FRAME_W    320     pixels per line
//  FRAME_H    240     lines per frame
//  ADDR_W     17      frame-buffer address width; must satisfy 2**ADDR_W >= FRAME_W*FRAME_H
//  SYNC_WORD  12'hFFF header word sent before pixel 0 of every frame
// PORTS
//  clk        in   1       system clock
//  rst        in   1       synchronous, active-high reset
//  start      in   1       1-cycle request to stream one frame; sampled only in IDLE
//  abort      in   1       cancel the frame in progress; returns to IDLE
//  rd_en      out  1       frame-buffer read strobe
//  rd_addr    out  ADDR_W  frame-buffer read address; valid when rd_en=1
//  rd_data    in   12      frame-buffer data; valid exactly 1 cycle after rd_en
//  pixel_out  out  12      word to send_pixel.pixel
//  valid_out  out  1       word valid (to send_pixel.valid_in)
//  ready_in   in   1       consumer ready (from send_pixel.ready_out)
//  busy       out  1       high in every state except IDLE
//  done       out  1       1-cycle pulse after the last pixel transfers
// BEHAVIOUR
//  Reset: state=IDLE; rd_en=0, rd_addr=0, pixel_out=0, valid_out=0, busy=0, done=0; addr counter=0.
//  Transfer: occurs on any rising edge where valid_out && ready_in are both 1.
//  While valid_out=1 and no transfer has occurred, pixel_out is held stable.
//  FSM (all outputs registered):
//   IDLE: start=1 -> HDR, addr:=0. A start seen in any other state is ignored.
//   HDR:  valid_out=1, pixel_out=SYNC_WORD. On a transfer -> READ.
//   READ: rd_en=1 and rd_addr=addr for exactly one cycle; valid_out=0 -> WAIT.
//   WAIT: pixel_out:=rd_data (captured this cycle) -> SEND.
//   SEND: valid_out=1. On a transfer:
//         if addr==FRAME_W*FRAME_H-1 -> DONE; else addr:=addr+1 -> READ.
//   DONE: done=1 for one cycle, valid_out=0 -> IDLE. busy=1 in this cycle.
//  Latency: start -> HDR valid in 1 cycle. Transfer -> next pixel valid in 3 cycles
//   (READ, WAIT, SEND). This rate far exceeds the UART rate, so no extra buffering is used.
//  addr never wraps: it stops at the last pixel. The compare is done at full ADDR_W width.
//  ready_in may be high before valid_out rises; this has no effect outside HDR and SEND.
//  abort (any non-IDLE state) -> IDLE on the next edge; valid_out, rd_en and busy drop;
//   done is NOT pulsed. If abort and a transfer happen in the same cycle, the consumer still
//   owns that word; the streamer discards its own progress.
//  start and abort in the same cycle while in IDLE: abort wins and the state stays IDLE.
//  rst has priority over all inputs and may be asserted in any state.
// TESTING (bench params FRAME_W=4, FRAME_H=2, ADDR_W=3; RAM model mem[i]=12'hA00+i, 1-cycle read)
//  1 ready_in tied 1, pulse start -> consumer sees FFF,A00,A01..A07 (9 words). Then one done
//    pulse. busy low the cycle after done.
//  2 ready_in toggled pseudo-randomly -> same 9-word sequence. pixel_out is stable while
//    valid_out && !ready_in. No word is duplicated or skipped.
//  3 Reset mid-frame after word A03 -> next cycle: all outputs 0, state IDLE. A new start
//    restarts with FFF,A00.
//  4 abort during SEND of A05 with ready_in=0 -> valid_out=0 next cycle, no done pulse.
//    A following start streams the full frame again.
//  5 start pulsed repeatedly while busy -> ignored; exactly 9 transfers and one done per frame.
//  6 rd_en check -> exactly 8 rd_en pulses per frame, with rd_addr 0..7 in order and never
//    more than one outstanding read.

Source files
------------

// File: rtl/frame_pixel_streamer.sv
// rtl/frame_pixel_streamer.sv - walks the frame buffer and streams SYNC_WORD + pixels over valid/ready
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start, abort      1-cycle frame request (IDLE only) / cancel current frame
//   rd_en, rd_addr    frame-buffer read strobe and address
//   rd_data           frame-buffer read data, valid one cycle after rd_en
//   pixel_out         word towards the pixel sender
//   valid_out         pixel_out is valid
//   ready_in          consumer accepts pixel_out on this edge when valid_out is high
//   busy              high in every state except IDLE
//   done              one-cycle pulse after the last pixel has transferred
module frame_pixel_streamer #(
  parameter int unsigned FRAME_W   = 320,
  parameter int unsigned FRAME_H   = 240,
  parameter int unsigned ADDR_W    = 17,
  parameter logic [11:0] SYNC_WORD = 12'hFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       rd_data,
  output logic [11:0]       pixel_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       LAST      = FRAME_W * FRAME_H - 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = LAST[ADDR_W-1:0];

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    READ = 3'd2,
    WAIT = 3'd3,
    SEND = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [11:0]       pixel_q, pixel_d;
  logic              xfer;

  // Outputs are decoded straight from registered state, so they never
  // depend combinationally on any input.
  assign valid_out = (state_q == HDR) || (state_q == SEND);
  assign rd_en     = (state_q == READ);
  assign rd_addr   = addr_q;
  assign pixel_out = pixel_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign xfer      = valid_out && ready_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pixel_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pixel_q <= pixel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pixel_d = pixel_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HDR;
          addr_d  = '0;
          pixel_d = SYNC_WORD;
        end
      end
      HDR: begin
        if (xfer) state_d = READ;
      end
      READ: begin
        state_d = WAIT;
      end
      WAIT: begin
        // rd_data belongs to the read issued in READ.
        pixel_d = rd_data;
        state_d = SEND;
      end
      SEND: begin
        if (xfer) begin
          if (addr_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Abort overrides everything, including a start seen in IDLE.
    if (abort) state_d = IDLE;
  end

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// tb/tb_frame_pixel_streamer.sv - directed self-checking bench for frame_pixel_streamer
module tb_frame_pixel_streamer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [11:0] rd_data;
  logic [11:0] pixel_out;
  logic        valid_out;
  logic        ready_in;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [11:0] got[$];
  int          done_cnt = 0;
  int          rd_cnt   = 0;
  logic        prev_rd   = 1'b0;
  logic        prev_hold = 1'b0;
  logic [11:0] prev_pix  = 12'h000;
  logic        stab_en   = 1'b0;
  logic        rnd_en    = 1'b0;
  logic [7:0]  lfsr      = 8'h5B;

  frame_pixel_streamer #(
    .FRAME_W(4),
    .FRAME_H(2),
    .ADDR_W(3),
    .SYNC_WORD(12'hFFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .pixel_out(pixel_out),
    .valid_out(valid_out),
    .ready_in(ready_in),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: mem[i] = 12'hA00 + i, one-cycle read latency.
  initial rd_data = 12'h000;
  always @(posedge clk) begin
    if (rd_en) rd_data <= 12'hA00 + {9'd0, rd_addr};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Consumer/read-port monitor, sampled mid-cycle: a word seen here with
  // valid_out && ready_in transfers on the following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_out && ready_in) got.push_back(pixel_out);
      if (done) done_cnt++;
      if (rd_en) begin
        chk("rd_addr_order", {29'd0, rd_addr}, rd_cnt);
        chk("rd_one_outstanding", {31'd0, prev_rd}, 32'd0);
        rd_cnt++;
      end
      if (stab_en && prev_hold) begin
        chk("hold_valid", {31'd0, valid_out}, 32'd1);
        chk("hold_pixel", {20'd0, pixel_out}, {20'd0, prev_pix});
      end
    end
    prev_rd   = rd_en;
    prev_hold = valid_out && !ready_in;
    prev_pix  = pixel_out;
  end

  // Advance to just after the next rising edge; inputs change only here.
  task automatic tick();
    @(posedge clk);
    #2;
    if (rnd_en) begin
      lfsr     = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      ready_in = lfsr[0];
    end
  endtask

  task automatic clear_scoreboard();
    got.delete();
    done_cnt = 0;
    rd_cnt   = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_count"}, got.size(), 32'd9);
    for (int i = 0; i < 9 && i < got.size(); i++) begin
      chk({tag, "_word"}, {20'd0, got[i]}, (i == 0) ? 32'hFFF : 32'hA00 + i - 1);
    end
    chk({tag, "_done_pulses"}, done_cnt, 32'd1);
    chk({tag, "_rd_pulses"}, rd_cnt, 32'd8);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_rd_en"},     {31'd0, rd_en},      32'd0);
    chk({tag, "_rd_addr"},   {29'd0, rd_addr},    32'd0);
    chk({tag, "_pixel_out"}, {20'd0, pixel_out},  32'd0);
    chk({tag, "_valid_out"}, {31'd0, valid_out},  32'd0);
    chk({tag, "_busy"},      {31'd0, busy},       32'd0);
    chk({tag, "_done"},      {31'd0, done},       32'd0);
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    ready_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_idle_zero("reset");

    // start and abort together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    chk("start_abort_idle_busy", {31'd0, busy}, 32'd0);

    // 1: ready tied high.
    clear_scoreboard();
    ready_in = 1'b1;
    pulse_start();
    chk("t1_hdr_valid", {31'd0, valid_out}, 32'd1);
    chk("t1_hdr_word", {20'd0, pixel_out}, 32'hFFF);
    chk("t1_hdr_busy", {31'd0, busy}, 32'd1);
    wait_done(100);
    chk("t1_busy_in_done", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_busy_after_done", {31'd0, busy}, 32'd0);
    chk("t1_done_one_cycle", {31'd0, done}, 32'd0);
    check_frame("t1");

    // 2: pseudo-random ready with hold-stability checking.
    clear_scoreboard();
    stab_en = 1'b1;
    rnd_en  = 1'b1;
    pulse_start();
    wait_done(400);
    rnd_en   = 1'b0;
    ready_in = 1'b1;
    tick();
    stab_en = 1'b0;
    check_frame("t2");

    // 3: reset right after A03 transferred.
    clear_scoreboard();
    pulse_start();
    n = 0;
    while (got.size() < 5 && n < 100) begin
      tick();
      n++;
    end
    chk("t3_reached_a03", got.size(), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("t3_reset");
    clear_scoreboard();
    pulse_start();
    wait_done(100);
    tick();
    check_frame("t3_restart");

    // 4: abort while A05 is presented and ready is low.
    clear_scoreboard();
    pulse_start();
    n = 0;
    while (got.size() < 6 && n < 100) begin
      tick();
      n++;
    end
    ready_in = 1'b0;
    n = 0;
    while (!(valid_out && pixel_out == 12'hA05) && n < 20) begin
      tick();
      n++;
    end
    chk("t4_send_a05", {20'd0, pixel_out}, 32'hA05);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_valid_dropped", {31'd0, valid_out}, 32'd0);
    chk("t4_busy_dropped", {31'd0, busy}, 32'd0);
    chk("t4_rd_en_dropped", {31'd0, rd_en}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("t4_no_done", done_cnt, 32'd0);
    chk("t4_words", got.size(), 32'd6);
    clear_scoreboard();
    ready_in = 1'b1;
    pulse_start();
    wait_done(100);
    tick();
    check_frame("t4_restart");

    // 5/6: start hammered while busy; read strobes checked by the monitor.
    clear_scoreboard();
    pulse_start();
    n = 0;
    while (!done && n < 100) begin
      start = ~start;
      tick();
      n++;
    end
    start = 1'b0;
    chk("t5_done_seen", {31'd0, done}, 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("t5_idle_after", {31'd0, busy}, 32'd0);
    check_frame("t5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
